// File: rtl/keypad_scan_4x4_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 matrix keypad scanner.
//   key_state_e   - debounce FSM states
//   frame_class_e - classification of one complete scan frame
//   KEY_CODE      - row-major (row*COLS+col) key-code table
//   key_map()     - index -> hex key code
package keypad_pkg;

  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 4;
  localparam int unsigned KEYS = ROWS * COLS;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    PRESSED,
    RELEASE_CHK
  } key_state_e;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } frame_class_e;

  // row0: 1 2 3 A / row1: 4 5 6 B / row2: 7 8 9 C / row3: E 0 F D
  localparam logic [3:0] KEY_CODE [KEYS] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  function automatic logic [3:0] key_map(input logic [3:0] idx);
    return KEY_CODE[idx];
  endfunction

endpackage

// File: rtl/keypad_scan_4x4_frame_classify.sv
// keypad_frame_classify: combinational classification of a 16-bit frame map.
//   frame_map   in  16  closed-switch map, bit row*4+col set = closed
//   frame_class out 2   frame_class_e encoding: NONE / SINGLE / MULTI
//   index       out 4   lowest set bit (the key index when SINGLE)
module keypad_frame_classify
  import keypad_pkg::*;
(
  input  logic [KEYS-1:0] frame_map,
  output logic [1:0]      frame_class,
  output logic [3:0]      index
);

  logic [4:0] ones;

  always_comb begin
    ones  = '0;
    index = '0;
    // Scan high to low so the final write leaves the lowest set bit.
    for (int unsigned i = KEYS; i > 0; i--) begin
      if (frame_map[i-1]) begin
        ones  = ones + 5'd1;
        index = 4'(i - 1);
      end
    end
    if (ones == 5'd0)      frame_class = NONE;
    else if (ones == 5'd1) frame_class = SINGLE;
    else                   frame_class = MULTI;
  end

endmodule

// File: rtl/keypad_scan_4x4.sv
// keypad_scan_4x4: 4x4 matrix keypad scanner with whole-frame debounce.
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   row_out    out  4  row drive, one-hot low
//   col_in     in   4  column sense, active-low, asynchronous
//   key_valid  out  one-clock strobe per accepted press
//   key_code   out  4  hex code of the last accepted key
//   key_down   out  debounced key currently held
//   multi_key  out  last frame had more than one closure
// Optional: define KEYPAD_REPEAT_EN for auto-repeat while a key is held.
module keypad_scan_4x4
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 100000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY_FRAMES = 125,
  parameter int unsigned REPEAT_RATE_FRAMES  = 25
`endif
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row_out,
  input  logic [3:0] col_in,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_down,
  output logic       multi_key
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int unsigned ROW_W = $clog2(ROWS);

  logic [COLS-1:0]  col_meta, col_sync;
  logic [DIV_W-1:0] div_cnt;
  logic [ROW_W-1:0] row_idx;
  logic             tick, frame_end;
  logic [KEYS-1:0]  frame_map, frame_next;

  logic [1:0]       cls_raw;
  frame_class_e     fclass;
  logic [3:0]       findex;

  key_state_e       state, state_next;
  logic [3:0]       cand, cand_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [3:0]       code_next;
  logic             down_next, valid_next, multi_next;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_DELAY_FRAMES + REPEAT_RATE_FRAMES + 1);
  logic [REP_W-1:0] rep_cnt, rep_next;
`endif

  assign tick      = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign frame_end = tick && (row_idx == ROW_W'(ROWS - 1));
  assign row_out   = ~(4'b0001 << row_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      row_idx <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      row_idx <= row_idx + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // The classifier sees the map including the row being latched on this
  // tick, so the frame is judged on the same edge that completes it.
  always_comb begin
    frame_next = frame_map;
    if (tick) frame_next[row_idx*COLS +: COLS] = ~col_sync;
  end

  always_ff @(posedge clk) begin
    if (rst) frame_map <= '0;
    else     frame_map <= frame_next;
  end

  keypad_frame_classify u_classify (
    .frame_map   (frame_next),
    .frame_class (cls_raw),
    .index       (findex)
  );

  assign fclass = frame_class_e'(cls_raw);

  always_comb begin
    state_next = state;
    cand_next  = cand;
    cnt_next   = cnt;
    code_next  = key_code;
    down_next  = key_down;
    valid_next = 1'b0;
    multi_next = multi_key;
`ifdef KEYPAD_REPEAT_EN
    rep_next   = rep_cnt;
`endif
    if (frame_end) begin
      multi_next = (fclass == MULTI);
      case (state)
        IDLE: begin
          if (fclass == SINGLE) begin
            if (DEBOUNCE_FRAMES == 1) begin
              state_next = PRESSED;
              code_next  = key_map(findex);
              down_next  = 1'b1;
              valid_next = 1'b1;
            end else begin
              state_next = PRESS_CHK;
              cand_next  = findex;
              cnt_next   = CNT_W'(1);
            end
          end
        end
        PRESS_CHK: begin
          if (fclass == SINGLE && findex == cand) begin
            if (cnt == CNT_W'(DEBOUNCE_FRAMES - 1)) begin
              state_next = PRESSED;
              code_next  = key_map(cand);
              down_next  = 1'b1;
              valid_next = 1'b1;
            end else begin
              cnt_next = cnt + 1'b1;
            end
          end else begin
            state_next = IDLE;
          end
        end
        PRESSED: begin
          if (fclass == NONE) begin
            if (DEBOUNCE_FRAMES == 1) begin
              state_next = IDLE;
              down_next  = 1'b0;
            end else begin
              state_next = RELEASE_CHK;
              cnt_next   = CNT_W'(1);
            end
          end else begin
`ifdef KEYPAD_REPEAT_EN
            // After the first repeat the counter parks at the delay value so
            // each further RATE frames re-hits the wrap point.
            if (rep_cnt == REP_W'(REPEAT_DELAY_FRAMES + REPEAT_RATE_FRAMES - 1)) begin
              rep_next   = REP_W'(REPEAT_DELAY_FRAMES);
              valid_next = 1'b1;
            end else begin
              rep_next = rep_cnt + 1'b1;
              if (rep_cnt == REP_W'(REPEAT_DELAY_FRAMES - 1)) valid_next = 1'b1;
            end
`endif
          end
        end
        RELEASE_CHK: begin
          if (fclass == NONE) begin
            if (cnt == CNT_W'(DEBOUNCE_FRAMES - 1)) begin
              state_next = IDLE;
              down_next  = 1'b0;
            end else begin
              cnt_next = cnt + 1'b1;
            end
          end else begin
            state_next = PRESSED;
          end
        end
        default: state_next = IDLE;
      endcase
    end
`ifdef KEYPAD_REPEAT_EN
    if (state_next != PRESSED) rep_next = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cand      <= '0;
      cnt       <= '0;
      key_code  <= '0;
      key_down  <= 1'b0;
      key_valid <= 1'b0;
      multi_key <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      state     <= state_next;
      cand      <= cand_next;
      cnt       <= cnt_next;
      key_code  <= code_next;
      key_down  <= down_next;
      key_valid <= valid_next;
      multi_key <= multi_next;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= rep_next;
`endif
    end
  end

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// tb_keypad_scan_4x4: self-checking bench for keypad_scan_4x4.
// A passive keypad model pulls columns low through closed switches on the
// driven row. Expected outputs come from a frame-history reference model.
module tb_keypad_scan_4x4;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEB      = 2;
  localparam int unsigned FRAME    = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row_out;
  logic [3:0] col_in;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_down;
  logic       multi_key;

  logic [15:0] keys = '0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic        m_down  = 1'b0;
  logic [3:0]  m_code  = 4'h0;
  logic        m_multi = 1'b0;
  logic        m_valid = 1'b0;
  logic [15:0] hist[$];

  logic [3:0] keytab [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  always #5 clk = ~clk;

  always_comb begin
    col_in = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && keys[r*4+c]) col_in[c] = 1'b0;
  end

  keypad_scan_4x4 #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_FRAMES (DEB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_out   (row_out),
    .col_in    (col_in),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_down  (key_down),
    .multi_key (multi_key)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic int lowest(input logic [15:0] m);
    for (int i = 0; i < 16; i++) if (m[i]) return i;
    return 0;
  endfunction

  // A press is accepted when nothing is held and the last DEB frames were
  // the same lone key; a release when something is held and the last DEB
  // frames were empty.
  task automatic model_frame(input logic [15:0] m);
    bit ok;
    int idx;
    hist.push_back(m);
    if (hist.size() > DEB) void'(hist.pop_front());
    m_multi = ($countones(m) > 1);
    m_valid = 1'b0;
    if (hist.size() == DEB) begin
      if (!m_down) begin
        ok = 1'b1;
        foreach (hist[i]) if ($countones(hist[i]) != 1 || hist[i] != hist[0]) ok = 1'b0;
        if (ok) begin
          idx     = lowest(m);
          m_down  = 1'b1;
          m_code  = keytab[idx/4][idx%4];
          m_valid = 1'b1;
        end
      end else begin
        ok = 1'b1;
        foreach (hist[i]) if (hist[i] != 16'h0) ok = 1'b0;
        if (ok) m_down = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_down  = 1'b0;
    m_code  = 4'h0;
    m_multi = 1'b0;
    m_valid = 1'b0;
  endtask

  // Entered at the negedge of cycle 0 of a frame; leaves at cycle 0 of the next.
  task automatic run_frame(input logic [15:0] m);
    logic [3:0] er;
    keys = m;
    for (int c = 0; c < FRAME; c++) begin
      er = ~(4'b0001 << (c / SCAN_DIV));
      check("row_out", 16'(row_out), 16'(er));
      check("key_valid", 16'(key_valid), (c == 0) ? 16'(m_valid) : 16'h0);
      check("key_down", 16'(key_down), 16'(m_down));
      check("key_code", 16'(key_code), 16'(m_code));
      check("multi_key", 16'(multi_key), 16'(m_multi));
      @(negedge clk);
    end
    model_frame(m);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_row_out"}, 16'(row_out), 16'hE);
    check({tag, "_key_valid"}, 16'(key_valid), 16'h0);
    check({tag, "_key_code"}, 16'(key_code), 16'h0);
    check({tag, "_key_down"}, 16'(key_down), 16'h0);
    check({tag, "_multi_key"}, 16'(multi_key), 16'h0);
  endtask

  localparam logic [15:0] K6  = 16'h0040; // row1,col2 -> 6
  localparam logic [15:0] K0  = 16'h0001; // row0,col0 -> 1
  localparam logic [15:0] K3  = 16'h0008; // row0,col3 -> A
  localparam logic [15:0] KMU = 16'h0021; // row0,col0 + row1,col1

  initial begin
    logic [15:0] prev;
    logic [15:0] cur;
    int r, a, b;

    rst  = 1'b1;
    keys = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // idle scanning
    run_frame(16'h0);
    run_frame(16'h0);
    // press 6 for three frames, accept after the second
    repeat (3) run_frame(K6);
    // release, key_down falls after the second empty frame
    repeat (3) run_frame(16'h0);
    // single-frame bounce: no accept
    run_frame(K0);
    repeat (2) run_frame(16'h0);
    // two keys together: multi_key, no accept
    run_frame(KMU);
    repeat (2) run_frame(16'h0);

    // randomized frames; a lone key is never followed directly by a
    // different lone key
    prev = '0;
    for (int f = 0; f < 48; f++) begin
      r = $urandom_range(0, 99);
      if (r < 40) begin
        cur = '0;
      end else if (r < 82) begin
        if ($countones(prev) == 1) cur = prev;
        else                       cur = 16'h1 << $urandom_range(0, 15);
      end else begin
        a   = $urandom_range(0, 15);
        b   = (a + $urandom_range(1, 15)) % 16;
        cur = (16'h1 << a) | (16'h1 << b);
      end
      run_frame(cur);
      prev = cur;
    end
    repeat (DEB + 1) run_frame(16'h0);

    // reset on the accepting frame-end edge suppresses the strobe
    run_frame(K3);
    keys = K3;
    for (int c = 0; c < FRAME - 1; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("midreset");
    model_reset();
    rst  = 1'b0;
    keys = '0;
    run_frame(16'h0);
    repeat (2) run_frame(K3);
    repeat (3) run_frame(16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
